// File: rtl/mux_8_1.sv
// Single-bit 8-to-1 mux with a combinational output, a registered tap and a
// one-hot decode of the select index.
module mux_8_1 #(
  parameter logic OQ_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i,
  input  logic [2:0] s,
  input  logic       en,
  output logic       o,
  output logic       o_q,
  output logic [7:0] sel_onehot
);

  logic oq_d;

  always_comb begin
    o          = i[s];
    sel_onehot = 8'b1 << s;
  end

  // rst overrides en; without en the flop simply recirculates.
  always_comb begin
    oq_d = o_q;
    if (rst)     oq_d = OQ_RESET;
    else if (en) oq_d = i[s];
  end

  always_ff @(posedge clk) begin
    o_q <= oq_d;
  end

endmodule

// File: tb/tb_mux_8_1.sv
// Directed bench for mux_8_1: combinational select, one-hot decode,
// registered tap with enable/hold and reset priority, exhaustive sweep.
module tb_mux_8_1;

  logic       clk;
  logic       rst;
  logic [7:0] i;
  logic [2:0] s;
  logic       en;
  logic       o;
  logic       o_q;
  logic [7:0] sel_onehot;

  int unsigned n_total;
  int unsigned n_pass;

  mux_8_1 #(.OQ_RESET(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .i          (i),
    .s          (s),
    .en         (en),
    .o          (o),
    .o_q        (o_q),
    .sel_onehot (sel_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_o_seq;
  logic [7:0] walk;
  logic       ref_o;

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    en  = 1'b0;
    i   = '0;
    s   = '0;
    #1;

    // Fixed pattern, s stepped 0..7, expected o = 0,1,1,0,1,1,1,0.
    exp_o_seq = 8'b0111_0110;
    i = 8'b0111_0110;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #2;
      check($sformatf("pat_o_s%0d", k), {7'b0, o}, {7'b0, exp_o_seq[k]});
      check($sformatf("onehot_s%0d", k), sel_onehot, 8'h01 << k);
    end

    // Walking one and walking zero on i for every s.
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 8; k++) begin
        walk = 8'h01 << w;
        i = walk;
        s = 3'(k);
        #1;
        check($sformatf("walk1_w%0d_s%0d", w, k), {7'b0, o}, {7'b0, (w == k)});
        i = ~walk;
        #1;
        check($sformatf("walk0_w%0d_s%0d", w, k), {7'b0, o}, {7'b0, (w != k)});
      end
    end

    // Registered path: reset, then load with enable.
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("oq_after_rst", {7'b0, o_q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    i   = 8'hA5;
    s   = 3'd2;
    tick();
    check("oq_load_s2", {7'b0, o_q}, 8'h01);
    @(negedge clk);
    s = 3'd1;
    tick();
    check("oq_load_s1", {7'b0, o_q}, 8'h00);
    @(negedge clk);
    s = 3'd0;
    tick();
    check("oq_load_s0", {7'b0, o_q}, 8'h01);

    // Hold: en low, o keeps tracking while o_q stays at 1.
    @(negedge clk);
    en = 1'b0;
    i  = 8'h00;
    s  = 3'd3;
    #1;
    check("hold_o_track0", {7'b0, o}, 8'h00);
    tick();
    check("hold_oq_a", {7'b0, o_q}, 8'h01);
    @(negedge clk);
    i = 8'h10;
    s = 3'd4;
    #1;
    check("hold_o_track1", {7'b0, o}, 8'h01);
    tick();
    check("hold_oq_b", {7'b0, o_q}, 8'h01);

    // Reset mid-operation with en low still clears; o keeps tracking.
    @(negedge clk);
    rst = 1'b1;
    i   = 8'hFF;
    s   = 3'd6;
    #1;
    check("rst_o_track", {7'b0, o}, 8'h01);
    tick();
    check("rst_en0_oq", {7'b0, o_q}, 8'h00);
    check("rst_onehot", sel_onehot, 8'h40);

    // Reset priority over en, then release.
    @(negedge clk);
    en = 1'b1;
    tick();
    check("rst_prio_oq", {7'b0, o_q}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_release_oq", {7'b0, o_q}, 8'h01);
    en = 1'b0;

    // Exhaustive sweep against an independent shift-based reference.
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 8; k++) begin
        i = 8'(v);
        s = 3'(k);
        #1;
        ref_o = 1'((v >> k) & 1);
        check($sformatf("exh_i%02h_s%0d", v, k), {7'b0, o}, {7'b0, ref_o});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
